axil_mem_init: RTL

- AXI4-Lite master engine that sits directly upstream of the AXI4-Lite RAM slave and drives its slave port.
- On a start pulse it fills a word-aligned region with an incrementing data pattern, then optionally reads the region back and compares it.
- Used for memory initialisation and scrub after reset, and as a built-in self-test for the RAM.
- Issues one outstanding transaction at a time, so it is safe with any compliant AXI4-Lite slave.

---
 rtl/axil_mem_init_pkg.sv | 16 +
 rtl/axil_mem_init.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_init_pkg.sv
// Shared state encoding and AXI4-Lite constants for the axil_mem_init fill/verify engine.
package axil_mem_init_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [1:0] AXIL_RESP_OKAY    = 2'b00;
  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_mem_init.sv
// AXI4-Lite master that fills a word region with seed+i and optionally reads it back to compare.
// Readback pass present only when AXIL_MEM_INIT_VERIFY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; captures the request
// WR_REQ  | AW and W offered together, each retired on its own handshake
// WR_RESP | waiting for B of the current word
// RD_REQ  | AR offered for the current word
// RD_RESP | waiting for R, compared against seed+i
// FIN     | one-cycle done pulse, back to IDLE
module axil_mem_init
  import axil_mem_init_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  verify,
  output logic                  busy,
  output logic                  done,
  output logic                  bresp_err,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic [CNT_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] seed_r;
  logic                  aw_done;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  last_word;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

`ifdef AXIL_MEM_INIT_VERIFY_EN
  logic                  verify_r;
  logic [CNT_WIDTH-1:0]  err_cnt_r;
  logic                  rd_bad;
  logic                  r_hs;
`endif

  // One counter drives both address and data: word i lives at base + i*STRB_WIDTH.
  assign word_addr = base_r + (ADDR_WIDTH'(idx) << ADDR_LSB);
  assign word_data = seed_r + DATA_WIDTH'(idx);
  assign last_word = (idx == (count_r - CNT_WIDTH'(1)));

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;
  assign b_hs  = m_axil_bvalid && m_axil_bready;

  assign m_axil_awaddr = word_addr;
  assign m_axil_awprot = AXIL_PROT_DEFAULT;
  assign m_axil_wdata  = word_data;
  assign m_axil_wstrb  = {STRB_WIDTH{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Valids are decoded from registered state only, so ready never reaches valid combinationally.
  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    done           = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (word_count == '0) ? FIN : WR_REQ;
        end
      end
      WR_REQ: begin
        busy           = 1'b1;
        m_axil_awvalid = !aw_done;
        m_axil_wvalid  = !w_done;
        if ((aw_done || m_axil_awready) && (w_done || m_axil_wready)) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        busy          = 1'b1;
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) begin
          if (!last_word) begin
            state_nxt = WR_REQ;
`ifdef AXIL_MEM_INIT_VERIFY_EN
          end else if (verify_r) begin
            state_nxt = RD_REQ;
`endif
          end else begin
            state_nxt = FIN;
          end
        end
      end
`ifdef AXIL_MEM_INIT_VERIFY_EN
      RD_REQ: begin
        busy           = 1'b1;
        m_axil_arvalid = 1'b1;
        if (m_axil_arready) begin
          state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        busy          = 1'b1;
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) begin
          state_nxt = last_word ? FIN : RD_REQ;
        end
      end
`endif
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r    <= '0;
      count_r   <= '0;
      seed_r    <= '0;
      idx       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bresp_err <= 1'b0;
    end else begin
      // AW and W retire independently; the flags are only meaningful inside WR_REQ.
      if (state != WR_REQ) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            base_r    <= base_addr & ADDR_MASK;
            count_r   <= word_count;
            seed_r    <= seed;
            idx       <= '0;
            bresp_err <= 1'b0;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            if (m_axil_bresp != AXIL_RESP_OKAY) bresp_err <= 1'b1;
            idx <= last_word ? '0 : idx + CNT_WIDTH'(1);
          end
        end
`ifdef AXIL_MEM_INIT_VERIFY_EN
        RD_RESP: begin
          if (r_hs) begin
            idx <= last_word ? '0 : idx + CNT_WIDTH'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef AXIL_MEM_INIT_VERIFY_EN
  assign r_hs   = m_axil_rvalid && m_axil_rready;
  assign rd_bad = (m_axil_rdata != word_data) || (m_axil_rresp != AXIL_RESP_OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      verify_r  <= 1'b0;
      err_cnt_r <= '0;
    end else if (state == IDLE && start) begin
      verify_r  <= verify;
      err_cnt_r <= '0;
    end else if (state == RD_RESP && r_hs && rd_bad && err_cnt_r != '1) begin
      err_cnt_r <= err_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign err_count     = err_cnt_r;
  assign m_axil_araddr = word_addr;
  assign m_axil_arprot = AXIL_PROT_DEFAULT;
`else
  logic unused_rd;
  assign unused_rd     = ^{verify, m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid};
  assign err_count     = '0;
  assign m_axil_araddr = '0;
  assign m_axil_arprot = AXIL_PROT_DEFAULT;
`endif

endmodule
